// File: rtl/tamagotchi_needs_core.sv
`default_nettype none
// ============================================================================
// Module   : tamagotchi_needs_core
// Purpose  : Needs engine for the tamagotchi. Keeps NUM_NEEDS independent
//            need levels that decay on game ticks, handles select/feed
//            presses and a long-press test mode, and drives the selected
//            need's level, face, alarm and an optional 7-segment digit.
// Options  : define SEG7_EN to build the 7-segment decoder; otherwise seg
//            is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module tamagotchi_needs_core #(
    parameter int                         NUM_NEEDS   = 4,
    parameter int                         LVL_W       = 4,
    parameter int                         LVL_MAX     = 10,
    parameter int                         LVL_INIT    = 8,
    parameter int                         HAPPY_TH    = 5,
    parameter int                         TICK_DIV    = 50_000_000,
    parameter int                         PER_W       = 8,
    parameter logic [NUM_NEEDS*PER_W-1:0] DECAY_TICKS = {8'd50, 8'd70, 8'd100, 8'd120},
    parameter int                         HOLD_TICKS  = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_NEEDS-1:0]         btn_need,
    input  logic                         btn_test,
    output logic [$clog2(NUM_NEEDS)-1:0] sel_idx,
    output logic [LVL_W-1:0]             level_out,
    output logic                         happy,
    output logic                         test_mode,
    output logic                         alarm,
    output logic [NUM_NEEDS*LVL_W-1:0]   levels,
    output logic [6:0]                   seg
);

    localparam int c_SEL_W  = $clog2(NUM_NEEDS);
    localparam int c_PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_HOLD_W = $clog2(HOLD_TICKS + 1);

    logic [c_PRE_W-1:0]  r_presc;
    logic                w_tick;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_test_mode;
    logic [c_SEL_W-1:0]  r_sel;
    logic                w_press;
    logic [c_SEL_W-1:0]  w_press_idx;
    logic [LVL_W-1:0]    w_lvl_arr [NUM_NEEDS];
    logic [NUM_NEEDS-1:0] w_zero;
    logic [LVL_W-1:0]    w_sel_lvl;
    logic [LVL_W-1:0]    r_level_out;
    logic                r_happy;
    logic                r_alarm;

    // Game-tick prescaler: one-cycle strobe every TICK_DIV clocks.
    assign w_tick = (r_presc == c_PRE_W'(TICK_DIV - 1));

    // Prescaler counter wraps on the tick strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRE_W'(1);
        end
    end

    // Press arbitration: lowest set button index wins.
    always_comb begin
        w_press     = 1'b0;
        w_press_idx = '0;
        for (int k = NUM_NEEDS - 1; k >= 0; k--) begin
            if (btn_need[k]) begin
                w_press     = 1'b1;
                w_press_idx = c_SEL_W'(k);
            end
        end
    end

    // Long-press detector: toggles test mode once per hold, saturates until release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_test_mode <= 1'b0;
        end else if (!btn_test) begin
            r_hold <= '0;
        end else if (w_tick && (r_hold != c_HOLD_W'(HOLD_TICKS))) begin
            r_hold <= r_hold + c_HOLD_W'(1);
            if (r_hold == c_HOLD_W'(HOLD_TICKS - 1)) begin
                r_test_mode <= ~r_test_mode;
            end
        end
    end

    // Selection register follows any accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (w_press) begin
            r_sel <= w_press_idx;
        end
    end

    for (genvar i = 0; i < NUM_NEEDS; i++) begin : g_need
        localparam logic [PER_W-1:0] c_PERIOD = DECAY_TICKS[i*PER_W +: PER_W];

        logic [PER_W-1:0] r_dcnt;
        logic [LVL_W-1:0] r_lvl;
        logic [LVL_W-1:0] w_lvl_nxt;
        logic             w_decay;
        logic             w_feed;

        assign w_decay = w_tick && !r_test_mode && (r_dcnt == c_PERIOD - PER_W'(1));
        assign w_feed  = w_press && (w_press_idx == c_SEL_W'(i)) && (r_sel == c_SEL_W'(i));

        // Decay timer counts ticks in normal mode, frozen in test mode.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dcnt <= '0;
            end else if (w_tick && !r_test_mode) begin
                r_dcnt <= w_decay ? '0 : r_dcnt + PER_W'(1);
            end
        end

        // Next level: feed and decay on the same cycle cancel except at the rails.
        always_comb begin
            w_lvl_nxt = r_lvl;
            if (w_feed && r_test_mode) begin
                w_lvl_nxt = (r_lvl == LVL_W'(1)) ? LVL_W'(LVL_MAX) : LVL_W'(1);
            end else if (w_feed && w_decay) begin
                if (r_lvl >= LVL_W'(LVL_MAX)) begin
                    w_lvl_nxt = LVL_W'(LVL_MAX - 1);
                end else if (r_lvl == '0) begin
                    w_lvl_nxt = LVL_W'(1);
                end
            end else if (w_feed) begin
                if (r_lvl < LVL_W'(LVL_MAX)) begin
                    w_lvl_nxt = r_lvl + LVL_W'(1);
                end
            end else if (w_decay) begin
                if (r_lvl != '0) begin
                    w_lvl_nxt = r_lvl - LVL_W'(1);
                end
            end
        end

        // Level register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lvl <= LVL_W'(LVL_INIT);
            end else begin
                r_lvl <= w_lvl_nxt;
            end
        end

        assign w_lvl_arr[i]                = r_lvl;
        assign w_zero[i]                   = (r_lvl == '0);
        assign levels[i*LVL_W +: LVL_W]    = r_lvl;
    end

    assign w_sel_lvl = w_lvl_arr[r_sel];

    // Display-side outputs are registered from the current state (one extra clock).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_out <= LVL_W'(LVL_INIT);
            r_happy     <= (LVL_INIT >= HAPPY_TH);
            r_alarm     <= (LVL_INIT == 0);
        end else begin
            r_level_out <= w_sel_lvl;
            r_happy     <= (w_sel_lvl >= LVL_W'(HAPPY_TH));
            r_alarm     <= |w_zero;
        end
    end

`ifdef SEG7_EN
    logic [6:0] r_seg;

    function automatic logic [6:0] f_seg7(input logic [LVL_W-1:0] v);
        int unsigned u;
        logic [6:0]  s;
        u = 32'(v);
        case (u)
            0:       s = 7'b0111111;
            1:       s = 7'b0000110;
            2:       s = 7'b1011011;
            3:       s = 7'b1001111;
            4:       s = 7'b1100110;
            5:       s = 7'b1101101;
            6:       s = 7'b1111101;
            7:       s = 7'b0000111;
            8:       s = 7'b1111111;
            9:       s = 7'b1101111;
            10:      s = 7'b1110111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Digit register tracks the selected level with the same latency as level_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= f_seg7(LVL_W'(LVL_INIT));
        end else begin
            r_seg <= f_seg7(w_sel_lvl);
        end
    end

    assign seg = r_seg;
`else
    assign seg = 7'b0000000;
`endif

    assign sel_idx   = r_sel;
    assign level_out = r_level_out;
    assign happy     = r_happy;
    assign alarm     = r_alarm;
    assign test_mode = r_test_mode;

endmodule
`default_nettype wire

// File: tb/tb_tamagotchi_needs_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tamagotchi_needs_core
// Purpose  : Self-checking bench for tamagotchi_needs_core. Two instances
//            (tick every clock, tick every third clock) share stimulus and
//            are compared each cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tamagotchi_needs_core;

    localparam int          LMAX  = 10;
    localparam int          LINIT = 8;
    localparam int          HTH   = 5;
    localparam int          HOLD  = 3;
    localparam logic [31:0] DT    = {8'd4, 8'd3, 8'd2, 8'd6};
    localparam int          PER [4] = '{6, 2, 3, 4};
    localparam int          TDV [2] = '{1, 3};

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] btn_need = 4'b0;
    logic       btn_test = 1'b0;
    logic       chk_en   = 1'b0;

    logic [1:0]  sel_a, sel_b;
    logic [3:0]  lo_a, lo_b;
    logic        hap_a, hap_b, tm_a, tm_b, al_a, al_b;
    logic [15:0] lv_a, lv_b;
    logic [6:0]  seg_a, seg_b;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state
    int         m_lvl [2][4];
    int         m_dc  [2][4];
    int         m_sel [2];
    int         m_hold[2];
    bit         m_tm  [2];
    int         m_cyc [2];
    int         e_lo  [2];
    bit         e_hap [2];
    bit         e_al  [2];
    logic [6:0] e_seg [2];

    always #5 clk = ~clk;

    tamagotchi_needs_core #(
        .NUM_NEEDS(4), .LVL_W(4), .LVL_MAX(LMAX), .LVL_INIT(LINIT), .HAPPY_TH(HTH),
        .TICK_DIV(1), .PER_W(8), .DECAY_TICKS(DT), .HOLD_TICKS(HOLD)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_need(btn_need), .btn_test(btn_test),
        .sel_idx(sel_a), .level_out(lo_a), .happy(hap_a), .test_mode(tm_a),
        .alarm(al_a), .levels(lv_a), .seg(seg_a)
    );

    tamagotchi_needs_core #(
        .NUM_NEEDS(4), .LVL_W(4), .LVL_MAX(LMAX), .LVL_INIT(LINIT), .HAPPY_TH(HTH),
        .TICK_DIV(3), .PER_W(8), .DECAY_TICKS(DT), .HOLD_TICKS(HOLD)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_need(btn_need), .btn_test(btn_test),
        .sel_idx(sel_b), .level_out(lo_b), .happy(hap_b), .test_mode(tm_b),
        .alarm(al_b), .levels(lv_b), .seg(seg_b)
    );

    function automatic logic [6:0] seg_of(input int v);
        logic [6:0] s;
        case (v)
            0:       s = 7'b0111111;
            1:       s = 7'b0000110;
            2:       s = 7'b1011011;
            3:       s = 7'b1001111;
            4:       s = 7'b1100110;
            5:       s = 7'b1101101;
            6:       s = 7'b1111101;
            7:       s = 7'b0000111;
            8:       s = 7'b1111111;
            9:       s = 7'b1101111;
            10:      s = 7'b1110111;
            default: s = 7'b0000000;
        endcase
`ifndef SEG7_EN
        s = 7'b0000000;
`endif
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int m);
        for (int i = 0; i < 4; i++) begin
            m_lvl[m][i] = LINIT;
            m_dc[m][i]  = 0;
        end
        m_sel[m]  = 0;
        m_hold[m] = 0;
        m_tm[m]   = 1'b0;
        m_cyc[m]  = 0;
        e_lo[m]   = LINIT;
        e_hap[m]  = (LINIT >= HTH);
        e_al[m]   = (LINIT == 0);
        e_seg[m]  = seg_of(LINIT);
    endtask

    // One clock of game rules for instance m.
    task automatic model_step(input int m);
        bit tick, feed, dec, any0;
        int k;
        tick = ((m_cyc[m] % TDV[m]) == TDV[m] - 1);
        m_cyc[m]++;
        e_lo[m]  = m_lvl[m][m_sel[m]];
        e_hap[m] = (e_lo[m] >= HTH);
        any0 = 1'b0;
        for (int i = 0; i < 4; i++) any0 |= (m_lvl[m][i] == 0);
        e_al[m]  = any0;
        e_seg[m] = seg_of(e_lo[m]);
        k = -1;
        for (int i = 3; i >= 0; i--) if (btn_need[i]) k = i;
        for (int i = 0; i < 4; i++) begin
            dec = 1'b0;
            if (tick && !m_tm[m]) begin
                m_dc[m][i]++;
                if (m_dc[m][i] == PER[i]) begin
                    dec = 1'b1;
                    m_dc[m][i] = 0;
                end
            end
            feed = (k == i) && (m_sel[m] == i);
            if (feed && m_tm[m])  m_lvl[m][i] = (m_lvl[m][i] == 1) ? LMAX : 1;
            else if (feed && dec) m_lvl[m][i] = (m_lvl[m][i] == LMAX) ? LMAX - 1 :
                                                (m_lvl[m][i] == 0) ? 1 : m_lvl[m][i];
            else if (feed)        m_lvl[m][i] = (m_lvl[m][i] < LMAX) ? m_lvl[m][i] + 1 : LMAX;
            else if (dec)         m_lvl[m][i] = (m_lvl[m][i] > 0) ? m_lvl[m][i] - 1 : 0;
        end
        if (k >= 0) m_sel[m] = k;
        if (!btn_test) m_hold[m] = 0;
        else if (tick && m_hold[m] < HOLD) begin
            m_hold[m]++;
            if (m_hold[m] == HOLD) m_tm[m] = !m_tm[m];
        end
    endtask

    task automatic cmp(input int m, input logic [1:0] sel, input logic [3:0] lo, input logic hap,
                       input logic tm, input logic al, input logic [15:0] lv, input logic [6:0] sg);
        logic [15:0] xl;
        string p;
        p = (m == 0) ? "a" : "b";
        for (int i = 0; i < 4; i++) xl[i*4 +: 4] = 4'(m_lvl[m][i]);
        chk({p, " sel_idx"},   32'(sel), 32'(m_sel[m]));
        chk({p, " levels"},    32'(lv),  32'(xl));
        chk({p, " test_mode"}, 32'(tm),  32'(m_tm[m]));
        chk({p, " level_out"}, 32'(lo),  32'(e_lo[m]));
        chk({p, " happy"},     32'(hap), 32'(e_hap[m]));
        chk({p, " alarm"},     32'(al),  32'(e_al[m]));
        chk({p, " seg"},       32'(sg),  32'(e_seg[m]));
    endtask

    // Reference model advances on every clock; reset is asynchronous.
    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // Cycle-by-cycle comparison, sampled on the inactive edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp(0, sel_a, lo_a, hap_a, tm_a, al_a, lv_a, seg_a);
                cmp(1, sel_b, lo_b, hap_b, tm_b, al_b, lv_b, seg_b);
            end
        end
    end

    // Apply inputs for one clock and return just after the next falling edge.
    task automatic step(input logic [3:0] bn, input logic bt);
        btn_need = bn;
        btn_test = bt;
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset(input logic bt);
        btn_need = 4'b0;
        btn_test = bt;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int hold_left;
        logic [3:0] bn;
        @(negedge clk);
        #2;
        repeat (2) @(negedge clk);
        #2;
        // Reset values
        chk("reset levels", 32'(lv_a), 32'h8888);
        chk("reset sel", 32'(sel_a), 32'd0);
        chk("reset happy", 32'(hap_a), 32'd1);
        chk("reset test_mode", 32'(tm_a), 32'd0);
        chk("reset level_out", 32'(lo_a), 32'd8);
`ifdef SEG7_EN
        chk("reset seg", 32'(seg_a), 32'h7F);
`else
        chk("reset seg", 32'(seg_a), 32'h00);
`endif
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Decay over 12 then 28 ticks
        repeat (12) step(4'b0, 1'b0);
        chk("decay12 a", 32'(lv_a), 32'h5426);
        chk("decay12 b", 32'(lv_b), 32'h7768);
        repeat (16) step(4'b0, 1'b0);
        chk("decay28 a", 32'(lv_a), 32'h1004);
        chk("decay28 b", 32'(lv_b), 32'h6547);
        chk("decay28 alarm", 32'(al_a), 32'd1);
        chk("decay28 level_out", 32'(lo_a), 32'd4);
        chk("decay28 happy", 32'(hap_a), 32'd0);

        // Select, feed to saturation, feed cancelled by decay
        do_reset(1'b0);
        repeat (4) step(4'b0100, 1'b0);
        chk("feed sel", 32'(sel_a), 32'd2);
        chk("feed sat", 32'(lv_a[11:8]), 32'd10);
        step(4'b0, 1'b0);
        chk("feed level_out", 32'(lo_a), 32'd10);
`ifdef SEG7_EN
        chk("feed seg", 32'(seg_a), 32'h77);
`else
        chk("feed seg", 32'(seg_a), 32'h00);
`endif
        step(4'b1010, 1'b0);
        chk("multi sel", 32'(sel_a), 32'd1);
        chk("multi need3", 32'(lv_a[15:12]), 32'd7);
        step(4'b0, 1'b0);
        step(4'b0010, 1'b0);
        chk("cancel need1", 32'(lv_a[7:4]), 32'd5);

        // Test mode entry, no re-toggle, toggle-feed, frozen decay
        do_reset(1'b0);
        repeat (3) step(4'b0, 1'b1);
        chk("test enter", 32'(tm_a), 32'd1);
        chk("test enter levels", 32'(lv_a), 32'h8778);
        repeat (10) step(4'b0, 1'b1);
        chk("test no retoggle", 32'(tm_a), 32'd1);
        step(4'b0001, 1'b0);
        chk("test feed to 1", 32'(lv_a[3:0]), 32'd1);
        step(4'b0001, 1'b0);
        chk("test feed to max", 32'(lv_a[3:0]), 32'd10);
        repeat (20) step(4'b0, 1'b0);
        chk("test frozen", 32'(lv_a), 32'h877A);

        // Reset in the middle of a hold discards progress
        do_reset(1'b0);
        repeat (2) step(4'b0, 1'b1);
        do_reset(1'b1);
        repeat (2) step(4'b0, 1'b1);
        chk("rst mid hold", 32'(tm_a), 32'd0);
        step(4'b0, 1'b0);

        // Randomised traffic checked by the model every cycle
        hold_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
                continue;
            end
            case ($urandom_range(0, 9))
                0, 1, 2: bn = 4'b0001 << $urandom_range(0, 3);
                3:       bn = 4'($urandom);
                default: bn = 4'b0;
            endcase
            if (hold_left > 0) hold_left--;
            else if ($urandom_range(0, 29) == 0) hold_left = $urandom_range(1, 16);
            step(bn, hold_left > 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
